// File: rtl/epwm_db_pkg.sv
// rtl/epwm_db_pkg.sv - shared encodings for the EPWM dead-band generator
//
// Purpose: mode and channel-state encodings plus the default counter width,
// imported by epwm_db_channel and epwm_deadband_gen.
// Ports: none (package).

package epwm_db_pkg;

  localparam int DB_WIDTH_DEFAULT = 10;

  // Source-selection modes; 2'b11 is decoded as complementary by the top.
  localparam logic [1:0] DB_MODE_BYPASS = 2'b00;
  localparam logic [1:0] DB_MODE_COMP   = 2'b01;
  localparam logic [1:0] DB_MODE_INDEP  = 2'b10;

  typedef enum logic [1:0] {
    DB_OFF  = 2'b00,
    DB_WAIT = 2'b01,
    DB_ON   = 2'b10
  } db_state_e;

endpackage

// File: rtl/epwm_db_channel.sv
// rtl/epwm_db_channel.sv - one dead-band channel: edge detect, OFF/WAIT/ON FSM, delay counter
//
// Purpose: delays the rising edge of src by `delay` clocks, passes the falling
// edge through immediately, swallows pulses shorter than the delay, and
// registers the polarity-adjusted output together with the FSM.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   src         channel source waveform
//   delay       rising-edge delay, captured on OFF->WAIT only
//   kill        force the FSM to OFF this edge (disable, mode change, trip)
//   force_low   with kill, drive out to 0 regardless of pol
//   pol         output inversion
//   raw         dead-banded level before polarity
//   out         registered pin value
//   active      channel is in WAIT

module epwm_db_channel
  import epwm_db_pkg::*;
#(
  parameter int DB_WIDTH = DB_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src,
  input  logic [DB_WIDTH-1:0] delay,
  input  logic                kill,
  input  logic                force_low,
  input  logic                pol,
  output logic                raw,
  output logic                out,
  output logic                active
);

  db_state_e           state_q;
  logic [DB_WIDTH-1:0] cnt_q;
  logic                s_d;
  logic                rise;
  logic                fall;

  assign rise   = src & ~s_d;
  assign fall   = ~src & s_d;
  assign active = (state_q == DB_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DB_OFF;
      cnt_q   <= '0;
      s_d     <= 1'b0;
      raw     <= 1'b0;
      out     <= 1'b0;
    end else begin
      // History always tracks the live source, so after a kill the channel
      // only restarts on a genuinely new rise.
      s_d <= src;
      out <= raw ^ pol;
      if (kill) begin
        state_q <= DB_OFF;
        cnt_q   <= '0;
        raw     <= 1'b0;
        out     <= force_low ? 1'b0 : pol;
      end else begin
        case (state_q)
          DB_OFF: begin
            if (rise) begin
              if (delay == '0) begin
                state_q <= DB_ON;
                raw     <= 1'b1;
                out     <= ~pol;
              end else begin
                state_q <= DB_WAIT;
                cnt_q   <= delay;
              end
            end
          end
          DB_WAIT: begin
            // A fall during the wait cancels the pulse entirely.
            if (fall) begin
              state_q <= DB_OFF;
              cnt_q   <= '0;
              raw     <= 1'b0;
              out     <= pol;
            end else if (cnt_q == DB_WIDTH'(1)) begin
              state_q <= DB_ON;
              cnt_q   <= '0;
              raw     <= 1'b1;
              out     <= ~pol;
            end else begin
              cnt_q <= cnt_q - DB_WIDTH'(1);
            end
          end
          DB_ON: begin
            if (fall) begin
              state_q <= DB_OFF;
              raw     <= 1'b0;
              out     <= pol;
            end
          end
          default: begin
            state_q <= DB_OFF;
            cnt_q   <= '0;
            raw     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/epwm_deadband_gen.sv
// rtl/epwm_deadband_gen.sv - EPWM dead-band generator top: source mux, polarity, trip, status
//
// Purpose: conditions raw PWM A/B into pin drives with programmable rising
// (RED) and falling (FED) dead time, selectable source mode and polarity.
// Optional trip zone enabled by defining EPWM_DB_TRIPZONE_EN.
// Ports:
//   FCB_CLK, FCB_RST     clock, asynchronous active-high reset
//   enable_i             0 forces both channels OFF
//   mode_i               00 bypass, 01/11 complementary from A, 10 independent
//   polarity_i           bit0 inverts epwm_a_o, bit1 inverts epwm_b_o
//   red_i, fed_i         channel A / channel B delays in clocks
//   pwm_a_i, pwm_b_i     raw PWM inputs
//   trip_i, trip_clr_i   (EPWM_DB_TRIPZONE_EN) trip request / sticky clear
//   tripped_o            (EPWM_DB_TRIPZONE_EN) sticky trip status
//   epwm_a_o, epwm_b_o   registered pin outputs
//   db_active_o          either channel is waiting out its dead time

module epwm_deadband_gen
  import epwm_db_pkg::*;
#(
  parameter int DB_WIDTH = DB_WIDTH_DEFAULT
) (
  input  logic                FCB_CLK,
  input  logic                FCB_RST,
  input  logic                enable_i,
  input  logic [1:0]          mode_i,
  input  logic [1:0]          polarity_i,
  input  logic [DB_WIDTH-1:0] red_i,
  input  logic [DB_WIDTH-1:0] fed_i,
  input  logic                pwm_a_i,
  input  logic                pwm_b_i,
`ifdef EPWM_DB_TRIPZONE_EN
  input  logic                trip_i,
  input  logic                trip_clr_i,
  output logic                tripped_o,
`endif
  output logic                epwm_a_o,
  output logic                epwm_b_o,
  output logic                db_active_o
);

  logic [1:0]          mode_q;
  logic                mode_vld_q;
  logic                mode_chg;
  logic                trip_force;
  logic                kill;
  logic                src_a, src_b;
  logic [DB_WIDTH-1:0] dly_a, dly_b;
  logic                raw_a, raw_b;
  logic                act_a, act_b;

  // mode_vld_q keeps the first edge after reset from looking like a mode
  // change, so a source already high at release is still seen as a rise.
  always_ff @(posedge FCB_CLK or posedge FCB_RST) begin
    if (FCB_RST) begin
      mode_q     <= DB_MODE_BYPASS;
      mode_vld_q <= 1'b0;
    end else begin
      mode_q     <= mode_i;
      mode_vld_q <= 1'b1;
    end
  end

  assign mode_chg = mode_vld_q & (mode_i != mode_q);

`ifdef EPWM_DB_TRIPZONE_EN
  always_ff @(posedge FCB_CLK or posedge FCB_RST) begin
    if (FCB_RST) begin
      tripped_o <= 1'b0;
    end else if (trip_i) begin
      tripped_o <= 1'b1;
    end else if (trip_clr_i) begin
      tripped_o <= 1'b0;
    end
  end

  // Outputs stay forced through the clearing edge; normal operation then
  // waits for a fresh source rise.
  assign trip_force = trip_i | tripped_o;
`else
  assign trip_force = 1'b0;
`endif

  assign kill = ~enable_i | mode_chg | trip_force;

  always_comb begin
    src_a = pwm_a_i;
    src_b = pwm_b_i;
    dly_a = '0;
    dly_b = '0;
    case (mode_i)
      DB_MODE_BYPASS: begin
        dly_a = '0;
        dly_b = '0;
      end
      DB_MODE_INDEP: begin
        dly_a = red_i;
        dly_b = fed_i;
      end
      default: begin
        // DB_MODE_COMP and the reserved 2'b11
        src_b = ~pwm_a_i;
        dly_a = red_i;
        dly_b = fed_i;
      end
    endcase
  end

  epwm_db_channel #(.DB_WIDTH(DB_WIDTH)) u_ch_a (
    .clk       (FCB_CLK),
    .rst       (FCB_RST),
    .src       (src_a),
    .delay     (dly_a),
    .kill      (kill),
    .force_low (trip_force),
    .pol       (polarity_i[0]),
    .raw       (raw_a),
    .out       (epwm_a_o),
    .active    (act_a)
  );

  epwm_db_channel #(.DB_WIDTH(DB_WIDTH)) u_ch_b (
    .clk       (FCB_CLK),
    .rst       (FCB_RST),
    .src       (src_b),
    .delay     (dly_b),
    .kill      (kill),
    .force_low (trip_force),
    .pol       (polarity_i[1]),
    .raw       (raw_b),
    .out       (epwm_b_o),
    .active    (act_b)
  );

  assign db_active_o = act_a | act_b;

endmodule

// File: tb/tb_epwm_deadband_gen.sv
// tb/tb_epwm_deadband_gen.sv - self-checking bench for epwm_deadband_gen

module tb_epwm_deadband_gen;

  localparam int DW = 10;

  logic          FCB_CLK = 1'b0;
  logic          FCB_RST = 1'b1;
  logic          enable_i = 1'b0;
  logic [1:0]    mode_i = 2'b00;
  logic [1:0]    polarity_i = 2'b00;
  logic [DW-1:0] red_i = '0;
  logic [DW-1:0] fed_i = '0;
  logic          pwm_a_i = 1'b0;
  logic          pwm_b_i = 1'b0;
`ifdef EPWM_DB_TRIPZONE_EN
  logic          trip_i = 1'b0;
  logic          trip_clr_i = 1'b0;
  logic          tripped_o;
`endif
  logic          epwm_a_o, epwm_b_o, db_active_o;

  int n_tests = 0;
  int n_fail  = 0;

  epwm_deadband_gen #(.DB_WIDTH(DW)) dut (
    .FCB_CLK     (FCB_CLK),
    .FCB_RST     (FCB_RST),
    .enable_i    (enable_i),
    .mode_i      (mode_i),
    .polarity_i  (polarity_i),
    .red_i       (red_i),
    .fed_i       (fed_i),
    .pwm_a_i     (pwm_a_i),
    .pwm_b_i     (pwm_b_i),
`ifdef EPWM_DB_TRIPZONE_EN
    .trip_i      (trip_i),
    .trip_clr_i  (trip_clr_i),
    .tripped_o   (tripped_o),
`endif
    .epwm_a_o    (epwm_a_o),
    .epwm_b_o    (epwm_b_o),
    .db_active_o (db_active_o)
  );

  always #5 FCB_CLK = ~FCB_CLK;

  // Reference model: each channel remembers its last sample, its output
  // level, and (while waiting) the absolute edge number its output is due.
  bit         m_prev[2];
  bit         m_raw[2];
  bit         m_pend[2];
  int         m_due[2];
  int         cyc;
  logic [1:0] m_mode;
  bit         m_mvld;
  bit         m_trip;
  logic       exp_a, exp_b, exp_act, exp_trip;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_prev[c] = 0; m_raw[c] = 0; m_pend[c] = 0; m_due[c] = 0;
    end
    m_mode = 2'b00; m_mvld = 0; m_trip = 0;
    exp_a = 0; exp_b = 0; exp_act = 0; exp_trip = 0;
  endtask

  task automatic model_edge();
    bit s[2];
    int d[2];
    bit kill, force0, rise, fall;
    logic [1:0] m;
    cyc++;
    m = (mode_i == 2'b11) ? 2'b01 : mode_i;
    s[0] = pwm_a_i;
    s[1] = (m == 2'b01) ? !pwm_a_i : pwm_b_i;
    d[0] = (m == 2'b00) ? 0 : int'(red_i);
    d[1] = (m == 2'b00) ? 0 : int'(fed_i);
    force0 = 0;
`ifdef EPWM_DB_TRIPZONE_EN
    force0 = trip_i || m_trip;
    if (trip_i) m_trip = 1;
    else if (trip_clr_i) m_trip = 0;
`endif
    kill = !enable_i || (m_mvld && mode_i != m_mode) || force0;
    m_mode = mode_i;
    m_mvld = 1;
    for (int c = 0; c < 2; c++) begin
      rise = s[c] && !m_prev[c];
      fall = !s[c] && m_prev[c];
      if (kill) begin
        m_raw[c] = 0; m_pend[c] = 0;
      end else if (m_pend[c]) begin
        if (fall) m_pend[c] = 0;
        else if (cyc == m_due[c]) begin m_raw[c] = 1; m_pend[c] = 0; end
      end else if (m_raw[c]) begin
        if (fall) m_raw[c] = 0;
      end else if (rise) begin
        if (d[c] == 0) m_raw[c] = 1;
        else begin m_pend[c] = 1; m_due[c] = cyc + d[c]; end
      end
      m_prev[c] = s[c];
    end
    exp_a    = force0 ? 1'b0 : (m_raw[0] ^ polarity_i[0]);
    exp_b    = force0 ? 1'b0 : (m_raw[1] ^ polarity_i[1]);
    exp_act  = m_pend[0] || m_pend[1];
    exp_trip = m_trip;
  endtask

  task automatic tick();
    @(posedge FCB_CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    FCB_RST = 1'b1;
    model_reset();
    @(posedge FCB_CLK);
    #1;
    FCB_RST = 1'b0;
  endtask

  task automatic test_reset();
    FCB_RST = 1'b1;
    enable_i = 1'b0;
    polarity_i = 2'b11;
    model_reset();
    @(posedge FCB_CLK);
    #1;
    if ({epwm_a_o, epwm_b_o, db_active_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=000", {epwm_a_o, epwm_b_o, db_active_o});
    end
    n_tests++;
    FCB_RST = 1'b0;
    tick();
    // polarity shows on the first edge after release while disabled
    if ({epwm_a_o, epwm_b_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_first_pol got=%b exp=11", {epwm_a_o, epwm_b_o});
    end
    n_tests++;
  endtask

  task automatic test_comp_edges();
    polarity_i = 2'b00; enable_i = 1; mode_i = 2'b01; red_i = 5; fed_i = 3; pwm_a_i = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({epwm_a_o, epwm_b_o, db_active_o} !== {exp_a, exp_b, exp_act}) begin
        n_fail++;
        $display("FAIL comp_settle cyc=%0d got=%b exp=%b", cyc, {epwm_a_o, epwm_b_o, db_active_o}, {exp_a, exp_b, exp_act});
      end
      n_tests++;
    end
    pwm_a_i = 1;
    tick();
    if ({epwm_a_o, epwm_b_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL comp_rise_edge got=%b exp=00", {epwm_a_o, epwm_b_o});
    end
    n_tests++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (epwm_a_o !== (i == 5)) begin
        n_fail++;
        $display("FAIL comp_red i=%0d got=%b exp=%b", i, epwm_a_o, (i == 5));
      end
      n_tests++;
    end
    for (int i = 0; i < 10; i++) tick();
    pwm_a_i = 0;
    tick();
    if ({epwm_a_o, epwm_b_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL comp_fall_edge got=%b exp=00", {epwm_a_o, epwm_b_o});
    end
    n_tests++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (epwm_b_o !== (i == 3) || epwm_a_o !== 1'b0) begin
        n_fail++;
        $display("FAIL comp_fed i=%0d got=%b%b exp=0%b", i, epwm_a_o, epwm_b_o, (i == 3));
      end
      n_tests++;
    end
  endtask

  task automatic test_swallow();
    int act_cnt;
    bit a_seen;
    mode_i = 2'b01; red_i = 8; fed_i = 0; pwm_a_i = 0; polarity_i = 0; enable_i = 1;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    act_cnt = 0;
    a_seen = 0;
    for (int i = 0; i < 16; i++) begin
      pwm_a_i = (i < 4);
      tick();
      act_cnt += int'(db_active_o);
      if (epwm_a_o) a_seen = 1;
      if ({epwm_a_o, epwm_b_o, db_active_o} !== {exp_a, exp_b, exp_act}) begin
        n_fail++;
        $display("FAIL swallow_model cyc=%0d got=%b exp=%b", cyc, {epwm_a_o, epwm_b_o, db_active_o}, {exp_a, exp_b, exp_act});
      end
      n_tests++;
    end
    if (act_cnt !== 4 || a_seen) begin
      n_fail++;
      $display("FAIL swallow_pulse active_cycles=%0d a_seen=%0d exp 4/0", act_cnt, a_seen);
    end
    n_tests++;
  endtask

  task automatic test_bypass_pol();
    logic ra, rb;
    mode_i = 2'b00; polarity_i = 2'b10; enable_i = 1; red_i = 7; fed_i = 9;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      pwm_a_i = ra;
      pwm_b_i = rb;
      tick();
      if (epwm_a_o !== ra || epwm_b_o !== ~rb) begin
        n_fail++;
        $display("FAIL bypass_pol i=%0d got=%b%b exp=%b%b", i, epwm_a_o, epwm_b_o, ra, ~rb);
      end
      n_tests++;
    end
    mode_i = 2'b01; polarity_i = 2'b00; red_i = 0; fed_i = 0;
    pwm_a_i = 1;
    tick();
    pwm_a_i = 0;
    tick();
    for (int i = 0; i < 30; i++) begin
      pwm_a_i = 1'($urandom_range(0, 1));
      tick();
      if (epwm_b_o !== ~epwm_a_o || {epwm_a_o, epwm_b_o} !== {exp_a, exp_b}) begin
        n_fail++;
        $display("FAIL comp_zero_db i=%0d got=%b%b exp=%b%b", i, epwm_a_o, epwm_b_o, exp_a, exp_b);
      end
      n_tests++;
    end
  endtask

  task automatic test_shadow();
    mode_i = 2'b10; red_i = 5; fed_i = 0; pwm_a_i = 0; pwm_b_i = 0; polarity_i = 0; enable_i = 1;
    do_reset();
    tick();
    tick();
    pwm_a_i = 1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) red_i = 20;
      tick();
      if (epwm_a_o !== (i >= 5)) begin
        n_fail++;
        $display("FAIL shadow_red i=%0d got=%b exp=%b", i, epwm_a_o, (i >= 5));
      end
      n_tests++;
    end
  endtask

  task automatic test_async_reset();
    mode_i = 2'b01; red_i = 10; fed_i = 0; pwm_a_i = 0; polarity_i = 2'b11; enable_i = 1;
    do_reset();
    tick();
    tick();
    pwm_a_i = 1;
    tick();
    tick();
    tick();
    #2;
    FCB_RST = 1'b1;
    model_reset();
    #1;
    if ({epwm_a_o, epwm_b_o, db_active_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=000", {epwm_a_o, epwm_b_o, db_active_o});
    end
    n_tests++;
    @(posedge FCB_CLK);
    #1;
    FCB_RST = 1'b0;
    for (int i = 0; i <= 11; i++) begin
      tick();
      if ({epwm_a_o, epwm_b_o, db_active_o} !== {exp_a, exp_b, exp_act} || epwm_a_o !== (i != 10 && i != 11)) begin
        n_fail++;
        $display("FAIL async_rerise i=%0d got=%b exp=%b", i, {epwm_a_o, epwm_b_o, db_active_o}, {exp_a, exp_b, exp_act});
      end
      n_tests++;
    end
  endtask

  task automatic test_random();
    mode_i = 2'b01; enable_i = 1; polarity_i = 0; red_i = 3; fed_i = 2;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) polarity_i = 2'($urandom_range(0, 3));
      enable_i = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) == 0) red_i = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) fed_i = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) pwm_a_i = ~pwm_a_i;
      if ($urandom_range(0, 5) == 0) pwm_b_i = ~pwm_b_i;
      tick();
      if ({epwm_a_o, epwm_b_o, db_active_o} !== {exp_a, exp_b, exp_act}) begin
        n_fail++;
        $display("FAIL random cyc=%0d mode=%b got=%b exp=%b", cyc, mode_i, {epwm_a_o, epwm_b_o, db_active_o}, {exp_a, exp_b, exp_act});
      end
      n_tests++;
    end
  endtask

`ifdef EPWM_DB_TRIPZONE_EN
  task automatic test_trip();
    mode_i = 2'b10; red_i = 0; fed_i = 0; polarity_i = 0; enable_i = 1;
    pwm_a_i = 1; pwm_b_i = 1; trip_i = 0; trip_clr_i = 0;
    do_reset();
    tick();
    for (int i = 0; i < 12; i++) begin
      trip_i     = (i == 1);
      trip_clr_i = (i == 6);
      polarity_i = (i >= 3 && i <= 6) ? 2'b11 : 2'b00;
      if (i == 9) begin pwm_a_i = 0; pwm_b_i = 0; end
      if (i == 10) begin pwm_a_i = 1; pwm_b_i = 1; end
      tick();
      if ({epwm_a_o, epwm_b_o, tripped_o} !== {exp_a, exp_b, exp_trip}
          || epwm_a_o !== (i == 0 || i >= 10) || tripped_o !== (i >= 1 && i <= 5)) begin
        n_fail++;
        $display("FAIL trip i=%0d got=%b exp=%b", i, {epwm_a_o, epwm_b_o, tripped_o}, {exp_a, exp_b, exp_trip});
      end
      n_tests++;
    end
  endtask
`endif

  initial begin
    cyc = 0;
    test_reset();
    test_comp_edges();
    test_swallow();
    test_bypass_pol();
    test_shadow();
    test_async_reset();
    test_random();
`ifdef EPWM_DB_TRIPZONE_EN
    test_trip();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
